brick_wall_ctrl: RTL and testbench

- Sequencer for a horizontal row of NUM_BRICKS bricks. It owns the per-brick exist bitmap and the shared wall Y position.
- Once per frame_tick it scans the bricks, one per cycle, against the ball box. It clears the brick that was hit, counts score, and steps the wall down on a frame-count schedule.
- It flags game_over when live bricks reach the floor, and all_clear when no bricks remain.
- Sits between the ball/paddle logic and the renderer. Replaces per-brick free-running FSMs with one scheduler.

---
 rtl/brick_pkg.sv | 18 +
 rtl/brick_hit_check.sv | 21 ++
 rtl/brick_wall_ctrl.sv | 152 +++++++++++++++
 tb/tb_brick_wall_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// brick_pkg: shared state encoding, default geometry and brick X helper for the brick wall
package brick_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, RESOLVE, DESCEND, OVER} state_t;
  localparam int NUM_BRICKS_D     = 8;
  localparam int COORD_W_D        = 10;
  localparam int X0_D             = 20;
  localparam int PITCH_D          = 60;
  localparam int BRICK_W_D        = 57;
  localparam int BRICK_H_D        = 19;
  localparam int BALL_SZ_D        = 20;
  localparam int INIT_Y_D         = 40;
  localparam int FLOOR_Y_D        = 458;
  localparam int DESCEND_FRAMES_D = 30;
  localparam int SPEED_D          = 1;
  function automatic int brick_x_pos(input int idx, input int x0, input int pitch);
    return x0 + idx * pitch;
  endfunction
endpackage

// File: rtl/brick_hit_check.sv
// brick_hit_check: combinational ball-box versus brick-box overlap test, one extra bit so sums never wrap
module brick_hit_check #(
  parameter int COORD_W = 10,
  parameter int BRICK_W = 57,
  parameter int BRICK_H = 19,
  parameter int BALL_SZ = 20
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W:0]   brick_x,
  input  logic [COORD_W-1:0] wall_y,
  output logic               match
);
  localparam int W = COORD_W + 1;
  logic [W-1:0] bx, by, wy;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign wy = {1'b0, wall_y};
  assign match = (bx <= brick_x + W'(BRICK_W)) && (bx + W'(BALL_SZ) >= brick_x) &&
                 (by <= wy + W'(BRICK_H)) && (by + W'(BALL_SZ) >= wy);
endmodule

// File: rtl/brick_wall_ctrl.sv
// brick_wall_ctrl: per-frame brick scan scheduler; define MULTI_HIT_EN to clear every matching brick per frame
module brick_wall_ctrl import brick_pkg::*; #(
  parameter int NUM_BRICKS     = NUM_BRICKS_D,
  parameter int COORD_W        = COORD_W_D,
  parameter int X0             = X0_D,
  parameter int PITCH          = PITCH_D,
  parameter int BRICK_W        = BRICK_W_D,
  parameter int BRICK_H        = BRICK_H_D,
  parameter int BALL_SZ        = BALL_SZ_D,
  parameter int INIT_Y         = INIT_Y_D,
  parameter int FLOOR_Y        = FLOOR_Y_D,
  parameter int DESCEND_FRAMES = DESCEND_FRAMES_D,
  parameter int SPEED          = SPEED_D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          frame_tick,
  input  logic [COORD_W-1:0]            ball_x,
  input  logic [COORD_W-1:0]            ball_y,
  output logic [NUM_BRICKS-1:0]         brick_exist,
  output logic [COORD_W-1:0]            wall_y,
  output logic                          hit,
  output logic [$clog2(NUM_BRICKS)-1:0] hit_idx,
  output logic [7:0]                    score,
  output logic                          busy,
  output logic                          game_over,
  output logic                          all_clear
);
  localparam int IDX_W = $clog2(NUM_BRICKS);
  localparam int FC_W  = $clog2(DESCEND_FRAMES + 1);
  localparam int CW1   = COORD_W + 1;
  localparam int CNT_W = $clog2(NUM_BRICKS + 1);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, hi_idx;
  logic [COORD_W-1:0] bx, by;
  logic [NUM_BRICKS-1:0] mmask;
  logic [FC_W-1:0] fcnt;
  logic [CNT_W-1:0] mcnt;
  logic [CW1-1:0] wy_step;
  logic [8:0] score_sum;
  logic match, rec, last, descend_now;
  brick_hit_check #(.COORD_W(COORD_W), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .BALL_SZ(BALL_SZ)) u_hit (
    .ball_x (bx),
    .ball_y (by),
    .brick_x(CW1'(brick_x_pos(int'(idx), X0, PITCH))),
    .wall_y (wall_y),
    .match  (match)
  );
  assign last = idx == IDX_W'(NUM_BRICKS - 1);
`ifdef MULTI_HIT_EN
  assign rec = match && brick_exist[idx];
`else
  assign rec = match && brick_exist[idx] && mmask == '0;
`endif
  assign descend_now = fcnt == FC_W'(DESCEND_FRAMES);
  assign wy_step = {1'b0, wall_y} + (descend_now ? CW1'(SPEED) : CW1'(0));
  assign score_sum = {1'b0, score} + 9'(mcnt);
  assign busy = state != IDLE && state != OVER;
  // count recorded matches and find the highest one for the resolve step
  always_comb begin
    mcnt = '0;
    hi_idx = '0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      if (mmask[i]) begin
        mcnt = mcnt + CNT_W'(1);
        hi_idx = IDX_W'(i);
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state: one frame walks SCAN -> RESOLVE -> DESCEND, then IDLE or OVER
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = frame_tick ? SCAN : IDLE;
        SCAN:    state_nxt = last ? RESOLVE : SCAN;
        RESOLVE: state_nxt = DESCEND;
        DESCEND: state_nxt = (brick_exist == '0 || wy_step >= CW1'(FLOOR_Y)) ? OVER : IDLE;
        default: state_nxt = state;
      endcase
    end
  end
  // datapath: ball latch, scan match mask, brick clearing, score, wall descent and end flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brick_exist <= '1;
      wall_y <= COORD_W'(INIT_Y);
      hit <= 1'b0;
      hit_idx <= '0;
      score <= '0;
      game_over <= 1'b0;
      all_clear <= 1'b0;
      fcnt <= '0;
      idx <= '0;
      mmask <= '0;
      bx <= '0;
      by <= '0;
    end else if (start) begin
      brick_exist <= '1;
      wall_y <= COORD_W'(INIT_Y);
      hit <= 1'b0;
      hit_idx <= '0;
      score <= '0;
      game_over <= 1'b0;
      all_clear <= 1'b0;
      fcnt <= '0;
      idx <= '0;
      mmask <= '0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            bx <= ball_x;
            by <= ball_y;
            idx <= '0;
            mmask <= '0;
          end
        end
        SCAN: begin
          if (rec) mmask[idx] <= 1'b1;
          idx <= idx + IDX_W'(1);
        end
        RESOLVE: begin
          if (|mmask) begin
            brick_exist <= brick_exist & ~mmask;
            hit <= 1'b1;
            hit_idx <= hi_idx;
            score <= score_sum > 9'd255 ? 8'd255 : score_sum[7:0];
          end
          fcnt <= fcnt + FC_W'(1);
        end
        DESCEND: begin
          if (descend_now) begin
            wall_y <= wy_step[COORD_W-1:0];
            fcnt <= '0;
          end
          if (brick_exist == '0) all_clear <= 1'b1;
          else if (wy_step >= CW1'(FLOOR_Y)) game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_brick_wall_ctrl.sv
// tb_brick_wall_ctrl: directed and randomized frame checks against a frame-level reference model
module tb_brick_wall_ctrl;
  logic clk = 0, rst = 1, start = 0, frame_tick = 0;
  logic [9:0] ball_x = 0, ball_y = 0;
  logic [7:0] brick_exist, exist2, score, score2;
  logic [9:0] wall_y, wall2;
  logic [2:0] hit_idx, hidx2;
  logic hit, hit2, busy, busy2, game_over, go2, all_clear, ac2;
  int errors = 0, checks = 0;
  int hits, busy_cyc, hits2, busy2_cyc;
  logic [7:0] m_exist;
  int m_score, m_wy, m_fc, m_hidx, m_hits, m_busy;
  bit m_go, m_ac;

  brick_wall_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y),
    .brick_exist(brick_exist), .wall_y(wall_y), .hit(hit), .hit_idx(hit_idx), .score(score),
    .busy(busy), .game_over(game_over), .all_clear(all_clear)
  );
  brick_wall_ctrl #(.SPEED(418)) dut2 (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y),
    .brick_exist(exist2), .wall_y(wall2), .hit(hit2), .hit_idx(hidx2), .score(score2),
    .busy(busy2), .game_over(go2), .all_clear(ac2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic m_reset;
    m_exist = 8'hFF; m_score = 0; m_wy = 40; m_fc = 0; m_go = 0; m_ac = 0; m_hidx = 0; m_hits = 0; m_busy = 0;
  endtask

  task automatic m_frame(input int x, input int y);
    int lo, hi, cnt, xi;
    logic [7:0] matched;
    m_hits = 0;
    m_busy = 0;
    if (m_go || m_ac) return;
    m_busy = 10;
    lo = -1; hi = -1; cnt = 0; matched = 0;
    for (int i = 0; i < 8; i++) begin
      xi = 20 + 60 * i;
      if (m_exist[i] && x <= xi + 57 && x + 20 >= xi && y <= m_wy + 19 && y + 20 >= m_wy) begin
        if (lo < 0) lo = i;
        hi = i;
        cnt++;
        matched[i] = 1'b1;
      end
    end
    if (cnt > 0) begin
      m_hits = 1;
`ifdef MULTI_HIT_EN
      m_exist = m_exist & ~matched;
      m_score = m_score + cnt;
      m_hidx = hi;
`else
      m_exist[lo] = 1'b0;
      m_score = m_score + 1;
      m_hidx = lo;
`endif
      if (m_score > 255) m_score = 255;
    end
    m_fc++;
    if (m_fc == 30) begin m_wy += 1; m_fc = 0; end
    if (m_exist == 0) m_ac = 1;
    else if (m_wy >= 458) m_go = 1;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    m_reset();
  endtask

  task automatic do_frame(input int x, input int y);
    hits = 0; busy_cyc = 0; hits2 = 0; busy2_cyc = 0;
    @(negedge clk); ball_x = 10'(x); ball_y = 10'(y); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    repeat (12) begin
      hits += int'(hit); busy_cyc += int'(busy); hits2 += int'(hit2); busy2_cyc += int'(busy2);
      @(negedge clk);
    end
    m_frame(x, y);
  endtask

  task automatic test_reset;
    #3 rst = 0;
    #1;
    checks++; if (brick_exist !== 8'hFF) begin errors++; $display("FAIL reset_exist act=%h req=ff", brick_exist); end
    checks++; if (wall_y !== 10'd40) begin errors++; $display("FAIL reset_wall act=%0d req=40", wall_y); end
    checks++; if (score !== 8'd0 || hit !== 1'b0 || hit_idx !== 3'd0) begin errors++; $display("FAIL reset_score_hit act=%0d/%b/%0d req=0/0/0", score, hit, hit_idx); end
    checks++; if (game_over !== 1'b0 || all_clear !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags act=%b%b%b req=000", game_over, all_clear, busy); end
    @(negedge clk); rst = 1;
    @(negedge clk);
    m_reset();
  endtask

  task automatic test_idle_frame;
    do_reset();
    do_frame(500, 300);
    checks++; if (brick_exist !== 8'hFF) begin errors++; $display("FAIL miss_exist act=%h req=ff", brick_exist); end
    checks++; if (wall_y !== 10'd40) begin errors++; $display("FAIL miss_wall act=%0d req=40", wall_y); end
    checks++; if (hits !== 0) begin errors++; $display("FAIL miss_hits act=%0d req=0", hits); end
    checks++; if (busy_cyc !== 10) begin errors++; $display("FAIL miss_busy_cycles act=%0d req=10", busy_cyc); end
  endtask

  task automatic test_single_hit;
    do_frame(85, 50);
    checks++; if (brick_exist !== 8'hFD) begin errors++; $display("FAIL hit1_exist act=%h req=fd", brick_exist); end
    checks++; if (hit_idx !== 3'd1) begin errors++; $display("FAIL hit1_idx act=%0d req=1", hit_idx); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL hit1_score act=%0d req=1", score); end
    checks++; if (hits !== 1) begin errors++; $display("FAIL hit1_pulses act=%0d req=1", hits); end
    do_frame(85, 50);
    checks++; if (hits !== 0 || score !== 8'd1) begin errors++; $display("FAIL hit1_repeat act=%0d/%0d req=0/1", hits, score); end
  endtask

  task automatic test_double;
    do_reset();
    do_frame(75, 50);
    checks++; if (hits !== 1) begin errors++; $display("FAIL dbl_pulses act=%0d req=1", hits); end
`ifdef MULTI_HIT_EN
    checks++; if (brick_exist !== 8'hFC || score !== 8'd2 || hit_idx !== 3'd1) begin errors++; $display("FAIL dbl_multi act=%h/%0d/%0d req=fc/2/1", brick_exist, score, hit_idx); end
`else
    checks++; if (brick_exist !== 8'hFE || score !== 8'd1 || hit_idx !== 3'd0) begin errors++; $display("FAIL dbl_single act=%h/%0d/%0d req=fe/1/0", brick_exist, score, hit_idx); end
`endif
  endtask

  task automatic test_descend;
    do_reset();
    repeat (29) do_frame(500, 300);
    checks++; if (wall_y !== 10'd40 || go2 !== 1'b0) begin errors++; $display("FAIL desc_29 act=%0d/%b req=40/0", wall_y, go2); end
    do_frame(500, 300);
    checks++; if (wall_y !== 10'd41) begin errors++; $display("FAIL desc_30 act=%0d req=41", wall_y); end
    checks++; if (go2 !== 1'b1 || wall2 !== 10'd458 || ac2 !== 1'b0) begin errors++; $display("FAIL floor_over act=%b/%0d/%b req=1/458/0", go2, wall2, ac2); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL desc_no_over act=%b req=0", game_over); end
    do_frame(85, 50);
    checks++; if (busy2_cyc !== 0 || hits2 !== 0 || exist2 !== 8'hFF || score2 !== 8'd0) begin errors++; $display("FAIL over_ignore act=%0d/%0d/%h/%0d req=0/0/ff/0", busy2_cyc, hits2, exist2, score2); end
    checks++; if (go2 !== 1'b1 || wall2 !== 10'd458) begin errors++; $display("FAIL over_hold act=%b/%0d req=1/458", go2, wall2); end
  endtask

  task automatic test_all_clear;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_frame(30 + 60 * i, 50);
      checks++; if (hits !== 1 || hit_idx !== 3'(i)) begin errors++; $display("FAIL clr_step%0d act=%0d/%0d req=1/%0d", i, hits, hit_idx, i); end
    end
    checks++; if (all_clear !== 1'b1 || score !== 8'd8 || brick_exist !== 8'h00 || game_over !== 1'b0) begin errors++; $display("FAIL clr_final act=%b/%0d/%h/%b req=1/8/00/0", all_clear, score, brick_exist, game_over); end
    do_frame(85, 50);
    checks++; if (busy_cyc !== 0 || all_clear !== 1'b1) begin errors++; $display("FAIL clr_hold act=%0d/%b req=0/1", busy_cyc, all_clear); end
    @(negedge clk); start = 1; frame_tick = 1;
    @(negedge clk); start = 0; frame_tick = 0;
    checks++; if (brick_exist !== 8'hFF || score !== 8'd0 || wall_y !== 10'd40 || all_clear !== 1'b0) begin errors++; $display("FAIL restart act=%h/%0d/%0d/%b req=ff/0/40/0", brick_exist, score, wall_y, all_clear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_priority act=%b req=0", busy); end
    m_reset();
  endtask

  task automatic test_reset_mid_scan;
    do_reset();
    @(negedge clk); ball_x = 10'd85; ball_y = 10'd50; frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_scan act=%b req=1", busy); end
    rst = 0;
    #1;
    checks++; if (busy !== 1'b0 || brick_exist !== 8'hFF || score !== 8'd0 || hit !== 1'b0) begin errors++; $display("FAIL mid_async act=%b/%h/%0d/%b req=0/ff/0/0", busy, brick_exist, score, hit); end
    @(negedge clk); rst = 1;
    hits = 0;
    repeat (12) begin hits += int'(hit); @(negedge clk); end
    checks++; if (hits !== 0 || brick_exist !== 8'hFF || score !== 8'd0) begin errors++; $display("FAIL mid_after act=%0d/%h/%0d req=0/ff/0", hits, brick_exist, score); end
    m_reset();
  endtask

  task automatic test_random;
    int x, y;
    do_reset();
    repeat (45) begin
      x = int'($urandom_range(0, 500));
      y = int'($urandom_range(0, 150));
      do_frame(x, y);
      checks++; if (brick_exist !== m_exist) begin errors++; $display("FAIL rnd_exist (%0d,%0d) act=%h req=%h", x, y, brick_exist, m_exist); end
      checks++; if (int'(score) !== m_score) begin errors++; $display("FAIL rnd_score act=%0d req=%0d", score, m_score); end
      checks++; if (int'(wall_y) !== m_wy) begin errors++; $display("FAIL rnd_wall act=%0d req=%0d", wall_y, m_wy); end
      checks++; if (hits !== m_hits || int'(hit_idx) !== m_hidx) begin errors++; $display("FAIL rnd_hit act=%0d/%0d req=%0d/%0d", hits, hit_idx, m_hits, m_hidx); end
      checks++; if (game_over !== m_go || all_clear !== m_ac || busy_cyc !== m_busy) begin errors++; $display("FAIL rnd_flags act=%b/%b/%0d req=%b/%b/%0d", game_over, all_clear, busy_cyc, m_go, m_ac, m_busy); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_idle_frame();
    test_single_hit();
    test_double();
    test_descend();
    test_all_clear();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
